player_position_datapath: RTL and testbench

- Datapath stage directly downstream of the player movement FSM. It consumes the FSM's one-hot state flags (input, update-position, set-A, set-D).
- Holds the player's horizontal position and applies a clamped step on each update.
- Drives the VGA plot interface: after each real position change it erases the old sprite and draws the new one, one pixel per clock.

---
 rtl/player_position_datapath_pkg.sv | 50 +++++
 rtl/player_position_datapath_sprite_scan_counter.sv | 58 +++++
 rtl/player_position_datapath.sv | 188 ++++++++++++++++++
 tb/tb_player_position_datapath.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/player_position_datapath_pkg.sv
// ---------------------------------------------------------------------------
// player_position_datapath_pkg
// Shared encodings for the player position datapath.
//   - dir_t           : latched movement direction (NONE / LEFT / RIGHT)
//   - render_state_t  : sprite render sequencer states
//   - SCREEN_W/H      : VGA plot surface in pixels (160 x 120)
//   - COLOUR_*        : 3-bit colour constants
//   - step_x()        : clamped horizontal step of the player position
// ---------------------------------------------------------------------------
package player_position_datapath_pkg;

    typedef enum logic [1:0] {
        DIR_NONE  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_t;

    typedef enum logic [1:0] {
        R_INIT  = 2'd0,
        R_IDLE  = 2'd1,
        R_ERASE = 2'd2,
        R_DRAW  = 2'd3
    } render_state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] COLOUR_BLACK = 3'b000;
    localparam logic [2:0] COLOUR_WHITE = 3'b111;

    // The compares are done before the add/subtract so the 8-bit result
    // can never wrap past the legal range.
    function automatic logic [7:0] step_x(
        input logic [7:0] x,
        input dir_t       dir,
        input logic [7:0] step,
        input logic [7:0] x_min,
        input logic [7:0] x_max
    );
        logic [7:0] result;
        result = x;
        case (dir)
            DIR_LEFT:  result = (x < x_min + step) ? x_min : x - step;
            DIR_RIGHT: result = (x > x_max - step) ? x_max : x + step;
            default:   result = x;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/player_position_datapath_sprite_scan_counter.sv
// ---------------------------------------------------------------------------
// sprite_scan_counter
// Row-major pixel scan over a SPRITE_W x SPRITE_H sprite, one pixel per
// enabled clock. Wraps back to (0,0) after the last pixel.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   i_clear  in   force counters to (0,0)
//   i_enable in   advance one pixel
//   o_cx     out  column within sprite
//   o_cy     out  row within sprite
//   o_last   out  high on the final pixel (cx==W-1 && cy==H-1)
// ---------------------------------------------------------------------------
module sprite_scan_counter #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 4,
    parameter int CX_W     = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
    parameter int CY_W     = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_clear,
    input  logic            i_enable,
    output logic [CX_W-1:0] o_cx,
    output logic [CY_W-1:0] o_cy,
    output logic            o_last
);

    localparam logic [CX_W-1:0] CX_LAST = CX_W'(SPRITE_W - 1);
    localparam logic [CY_W-1:0] CY_LAST = CY_W'(SPRITE_H - 1);

    logic [CX_W-1:0] r_cx;
    logic [CY_W-1:0] r_cy;
    logic            w_cx_end;
    logic            w_cy_end;

    assign w_cx_end = (r_cx == CX_LAST);
    assign w_cy_end = (r_cy == CY_LAST);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_enable) begin
            if (w_cx_end) begin
                r_cx <= '0;
                r_cy <= w_cy_end ? '0 : r_cy + 1'b1;
            end else begin
                r_cx <= r_cx + 1'b1;
            end
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = w_cx_end && w_cy_end;

endmodule

// File: rtl/player_position_datapath.sv
// ---------------------------------------------------------------------------
// player_position_datapath
// Holds the player's horizontal position, applies clamped steps when the
// movement FSM is in its update state, and re-renders the sprite (erase old,
// draw new) through the VGA plot interface one pixel per clock.
// Ports:
//   clk                    in   system clock
//   reset                  in   synchronous active-high reset
//   inInputState           in   FSM waiting for input (no action here)
//   inUpdatePositionState  in   apply latched direction this cycle
//   inSetAState            in   latch direction LEFT
//   inSetDState            in   latch direction RIGHT (wins over LEFT)
//   playerX                out  current logical player X
//   busy                   out  render sequence in progress
//   plot                   out  VGA write strobe
//   vgaX / vgaY            out  pixel coordinate
//   colour                 out  pixel colour
//
// Render FSM
//   state   | meaning
//   R_INIT  | one quiet cycle after reset, then initial draw
//   R_IDLE  | sprite on screen matches drawn X, waiting for pending
//   R_ERASE | painting background over the sprite at drawn X
//   R_DRAW  | painting the sprite at drawn X (updated to target X)
// ---------------------------------------------------------------------------
module player_position_datapath
    import player_position_datapath_pkg::*;
#(
    parameter int         X_START       = 76,
    parameter int         X_MIN         = 0,
    parameter int         X_MAX         = 152,
    parameter int         Y_POS         = 110,
    parameter int         STEP          = 2,
    parameter int         SPRITE_W      = 8,
    parameter int         SPRITE_H      = 4,
    parameter logic [2:0] PLAYER_COLOUR = COLOUR_WHITE,
    parameter logic [2:0] BG_COLOUR     = COLOUR_BLACK
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inInputState,
    input  logic       inUpdatePositionState,
    input  logic       inSetAState,
    input  logic       inSetDState,
    output logic [7:0] playerX,
    output logic       busy,
    output logic       plot,
    output logic [7:0] vgaX,
    output logic [6:0] vgaY,
    output logic [2:0] colour
);

    localparam int CX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int CY_W = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

    localparam logic [7:0] C_X_START = 8'(X_START);
    localparam logic [7:0] C_X_MIN   = 8'(X_MIN);
    localparam logic [7:0] C_X_MAX   = 8'(X_MAX);
    localparam logic [7:0] C_STEP    = 8'(STEP);
    localparam logic [6:0] C_Y_POS   = 7'(Y_POS);

    render_state_t   r_state;
    render_state_t   w_state_next;
    dir_t            r_dir;
    logic [7:0]      r_player_x;
    logic [7:0]      r_drawn_x;
    logic [7:0]      r_target_x;
    logic            r_pending;

    logic [7:0]      w_new_x;
    logic            w_moved;
    logic            w_scanning;
    logic            w_enter_erase;
    logic [CX_W-1:0] w_cx;
    logic [CY_W-1:0] w_cy;
    logic            w_last;

    // The input-state flag carries no work for this stage.
    logic            w_unused;
    assign w_unused = inInputState;

    assign w_new_x    = step_x(r_player_x, r_dir, C_STEP, C_X_MIN, C_X_MAX);
    assign w_moved    = inUpdatePositionState && (w_new_x != r_player_x);
    assign w_scanning = (r_state == R_ERASE) || (r_state == R_DRAW);

    sprite_scan_counter #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .CX_W     (CX_W),
        .CY_W     (CY_W)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (!w_scanning),
        .i_enable (w_scanning),
        .o_cx     (w_cx),
        .o_cy     (w_cy),
        .o_last   (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        plot         = 1'b0;
        busy         = 1'b0;
        vgaX         = 8'd0;
        vgaY         = 7'd0;
        colour       = BG_COLOUR;
        case (r_state)
            R_INIT: begin
                w_state_next = R_DRAW;
            end
            R_IDLE: begin
                if (r_pending) begin
                    w_state_next = R_ERASE;
                end
            end
            R_ERASE: begin
                plot   = 1'b1;
                busy   = 1'b1;
                vgaX   = r_drawn_x + 8'(w_cx);
                vgaY   = C_Y_POS + 7'(w_cy);
                colour = BG_COLOUR;
                if (w_last) begin
                    w_state_next = R_DRAW;
                end
            end
            R_DRAW: begin
                plot   = 1'b1;
                busy   = 1'b1;
                vgaX   = r_drawn_x + 8'(w_cx);
                vgaY   = C_Y_POS + 7'(w_cy);
                colour = PLAYER_COLOUR;
                if (w_last) begin
                    w_state_next = r_pending ? R_ERASE : R_IDLE;
                end
            end
            default: begin
                w_state_next = R_INIT;
            end
        endcase
    end

    assign w_enter_erase = (r_state != R_ERASE) && (w_state_next == R_ERASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= R_INIT;
            r_dir      <= DIR_NONE;
            r_player_x <= C_X_START;
            r_drawn_x  <= C_X_START;
            r_target_x <= C_X_START;
            r_pending  <= 1'b0;
        end else begin
            r_state <= w_state_next;

            // Set-D is ordered last so it wins when both set flags are high.
            if (inUpdatePositionState) begin
                r_dir      <= DIR_NONE;
                r_player_x <= w_new_x;
            end
            if (inSetAState) begin
                r_dir <= DIR_LEFT;
            end
            if (inSetDState) begin
                r_dir <= DIR_RIGHT;
            end

            // The draw target is captured when a pass starts, so updates that
            // arrive mid-pass leave this pass intact and are picked up by one
            // follow-up pass. A move in the same cycle as the capture
            // re-arms pending so it is never dropped.
            if (w_enter_erase) begin
                r_pending  <= 1'b0;
                r_target_x <= r_player_x;
            end
            if (w_moved) begin
                r_pending <= 1'b1;
            end

            if ((r_state == R_ERASE) && w_last) begin
                r_drawn_x <= r_target_x;
            end
        end
    end

    assign playerX = r_player_x;

endmodule

// File: tb/tb_player_position_datapath.sv
module tb_player_position_datapath;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_input = 1'b0;
    logic       in_update = 1'b0;
    logic       in_set_a = 1'b0;
    logic       in_set_d = 1'b0;
    logic [7:0] player_x;
    logic       busy;
    logic       plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;

    always #5 clk = ~clk;

    player_position_datapath dut (
        .clk                   (clk),
        .reset                 (reset),
        .inInputState          (in_input),
        .inUpdatePositionState (in_update),
        .inSetAState           (in_set_a),
        .inSetDState           (in_set_d),
        .playerX               (player_x),
        .busy                  (busy),
        .plot                  (plot),
        .vgaX                  (vga_x),
        .vgaY                  (vga_y),
        .colour                (colour)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        bit         a;
        bit         d;
        bit         inp;
        int         prep;
        logic [7:0] exp_x;
        bit         exp_render;
    } vec_t;

    pix_t       exp_q[$];
    pix_t       mon_e;
    vec_t       vecs[11];
    int         n_checks = 0;
    int         n_pass = 0;
    int         plot_cnt = 0;
    int         cyc = 0;
    int         first_plot = -1;
    int         last_plot = -1;
    bit         chk_en = 1'b1;
    logic [7:0] m_x = 8'd76;
    logic [7:0] m_drawn = 8'd76;
    int         m_dir = 0;

    // Scoreboard: every plotted pixel is checked against the queue head.
    always @(negedge clk) begin
        cyc++;
        if (!reset && plot) begin
            plot_cnt++;
            if (first_plot < 0) first_plot = cyc;
            last_plot = cyc;
            if (chk_en) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%b, required no plot",
                             vga_x, vga_y, colour);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (vga_x === mon_e.x && vga_y === mon_e.y && colour === mon_e.c)
                        n_pass++;
                    else
                        $display("FAIL pixel: got x=%0d y=%0d colour=%b, required x=%0d y=%0d colour=%b",
                                 vga_x, vga_y, colour, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endtask

    function automatic logic [7:0] mstep(input logic [7:0] x, input int dir);
        int v;
        v = int'(x);
        if (dir == 2) v = v + 2;
        else if (dir == 1) v = v - 2;
        if (v < 0) v = 0;
        if (v > 152) v = 152;
        return 8'(v);
    endfunction

    task automatic push_block(input logic [7:0] x0, input logic [2:0] c);
        pix_t p;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 8; x++) begin
                p.x = x0 + 8'(x);
                p.y = 7'(110 + y);
                p.c = c;
                exp_q.push_back(p);
            end
        end
    endtask

    task automatic push_pass(input logic [7:0] ex, input logic [7:0] dx);
        push_block(ex, 3'b000);
        push_block(dx, 3'b111);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dir(input bit a, input bit d, input bit inp);
        in_set_a = a;
        in_set_d = d;
        in_input = inp;
        tick();
        in_set_a = 1'b0;
        in_set_d = 1'b0;
        in_input = 1'b0;
        if (d) m_dir = 2;
        else if (a) m_dir = 1;
    endtask

    task automatic do_update();
        in_update = 1'b1;
        tick();
        in_update = 1'b0;
        m_x = mstep(m_x, m_dir);
        m_dir = 0;
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 400 && quiet < 3; i++) begin
            @(negedge clk);
            #1;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            n_checks++;
            $display("FAIL idle_timeout: got busy=%0d after 400 cycles, required 0", busy);
        end
    endtask

    task automatic wait_plots(input int n);
        int i = 0;
        while (plot_cnt < n && i < 200) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (plot_cnt < n) begin
            n_checks++;
            $display("FAIL plot_timeout: got %0d plots, required %0d", plot_cnt, n);
        end
    endtask

    task automatic bulk_move(input logic [7:0] target);
        chk_en = 1'b0;
        for (int i = 0; i < 200 && m_x != target; i++) begin
            if (target < m_x) set_dir(1'b1, 1'b0, 1'b0);
            else set_dir(1'b0, 1'b1, 1'b0);
            do_update();
        end
        wait_idle();
        exp_q.delete();
        m_drawn = m_x;
        chk_en = 1'b1;
        chk("bulk_x", int'(player_x), int'(target));
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, -1,  8'd74,  1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, -1,  8'd76,  1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, -1,  8'd76,  1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, -1,  8'd78,  1'b1};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, -1,  8'd78,  1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 2,   8'd0,   1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, -1,  8'd0,   1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 150, 8'd152, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, -1,  8'd152, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, -1,  8'd152, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, -1,  8'd150, 1'b1};

        // Reset, INIT cycle, initial draw at X_START.
        repeat (3) tick();
        plot_cnt = 0;
        push_block(8'd76, 3'b111);
        reset = 1'b0;
        @(negedge clk);
        chk("init_plot", int'(plot), 0);
        chk("init_busy", int'(busy), 0);
        chk("init_vga_x", int'(vga_x), 0);
        chk("init_vga_y", int'(vga_y), 0);
        chk("init_colour", int'(colour), 0);
        chk("init_player_x", int'(player_x), 76);
        wait_idle();
        chk("init_plots", plot_cnt, 32);
        chk("init_queue", exp_q.size(), 0);

        foreach (vecs[k]) begin
            if (vecs[k].prep >= 0) bulk_move(8'(vecs[k].prep));
            if (vecs[k].a || vecs[k].d || vecs[k].inp)
                set_dir(vecs[k].a, vecs[k].d, vecs[k].inp);
            plot_cnt = 0;
            if (vecs[k].exp_render) begin
                push_pass(m_drawn, vecs[k].exp_x);
                m_drawn = vecs[k].exp_x;
            end
            do_update();
            chk("vec_player_x", int'(player_x), int'(vecs[k].exp_x));
            wait_idle();
            chk("vec_plot_cycles", plot_cnt, vecs[k].exp_render ? 64 : 0);
            chk("vec_queue", exp_q.size(), 0);
        end

        // Second update during the erase: one follow-up pass.
        plot_cnt = 0;
        first_plot = -1;
        set_dir(1'b1, 1'b0, 1'b0);
        push_pass(8'd150, 8'd148);
        do_update();
        wait_plots(10);
        set_dir(1'b1, 1'b0, 1'b0);
        do_update();
        chk("dbl_player_x", int'(player_x), 146);
        push_pass(8'd148, 8'd146);
        wait_idle();
        chk("dbl_plots", plot_cnt, 128);
        chk("dbl_span_ok", int'((last_plot - first_plot + 1) <= 129), 1);
        chk("dbl_queue", exp_q.size(), 0);

        // Update landing on the last draw pixel.
        plot_cnt = 0;
        first_plot = -1;
        set_dir(1'b1, 1'b0, 1'b0);
        push_pass(8'd146, 8'd144);
        do_update();
        set_dir(1'b1, 1'b0, 1'b0);
        wait_plots(64);
        do_update();
        chk("last_px_player_x", int'(player_x), 142);
        push_pass(8'd144, 8'd142);
        wait_idle();
        chk("last_px_plots", plot_cnt, 128);
        chk("last_px_span", last_plot - first_plot + 1, 129);
        chk("last_px_queue", exp_q.size(), 0);

        // Reset during draw pixel 17.
        plot_cnt = 0;
        set_dir(1'b0, 1'b1, 1'b0);
        push_pass(8'd142, 8'd144);
        do_update();
        wait_plots(49);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_player_x", int'(player_x), 76);
        exp_q.delete();
        push_block(8'd76, 3'b111);
        m_x = 8'd76;
        m_drawn = 8'd76;
        m_dir = 0;
        plot_cnt = 0;
        tick();
        reset = 1'b0;
        wait_idle();
        chk("rst_plots", plot_cnt, 32);
        chk("rst_queue", exp_q.size(), 0);
        chk("rst_final_x", int'(player_x), 76);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
